// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier: ALU opcodes, sequencer state
// encodings and the registered result payload.
package alu_mul_sequencer_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned STATE_W   = 2;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 4'b0101;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [2*MUL_WIDTH-1:0] product;
        logic                   z_flag;
        logic                   n_flag;
    } mul_result_t;

    // Product plus the flags derived from it.
    function automatic mul_result_t make_result(input logic [2*MUL_WIDTH-1:0] p);
        mul_result_t r;
        r.product = p;
        r.z_flag  = (p == '0);
        r.n_flag  = p[2*MUL_WIDTH-1];
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Project ALU: purely combinational, port order (Out,Z,N,C,V,A,B,Op).
module alu_mul_sequencer_alu
    import alu_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    output logic [WIDTH-1:0]    out_c,
    output logic                z_c,
    output logic                n_c,
    output logic                c_c,
    output logic                v_c,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op
);

    logic [WIDTH:0] sum;

    // C is the bit above the result: carry for ADD, borrow for SUB, 0 otherwise.
    always_comb begin
        sum = {1'b0, a};
        v_c = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                v_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                v_c = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:    sum = {1'b0, a & b};
            ALU_OR:     sum = {1'b0, a | b};
            ALU_XOR:    sum = {1'b0, a ^ b};
            ALU_PASS_A: sum = {1'b0, a};
            default:    sum = {1'b0, a};
        endcase
        out_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        n_c   = sum[WIDTH-1];
        z_c   = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32->64 unsigned multiplier: one ALU add per cycle, shifting the
// 65-bit {C,hi,lo} right each step, with a start/busy/done handshake.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int unsigned          WIDTH  = MUL_WIDTH,
    parameter logic [ALU_OP_W-1:0]  ADD_OP = ALU_ADD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 z_flag,
    output logic                 n_flag
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    mul_result_t        res_q, res_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_c;
    logic               alu_z_unused;
    logic               alu_n_unused;
    logic               alu_v_unused;

    assign alu_b = lo_q[0] ? m_q : '0;

    alu_mul_sequencer_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .out_c (alu_out),
        .z_c   (alu_z_unused),
        .n_c   (alu_n_unused),
        .c_c   (alu_c),
        .v_c   (alu_v_unused),
        .a     (hi_q),
        .b     (alu_b),
        .op    (ADD_OP)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        res_d   = res_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    hi_d    = '0;
                    lo_d    = multiplier;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry is kept even when B=0 so the shift stays 65 bits wide.
                hi_d    = {alu_c, alu_out[WIDTH-1:1]};
                lo_d    = {alu_out[0], lo_q[WIDTH-1:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                res_d   = make_result({hi_q, lo_q});
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // busy covers the done pulse so it only falls together with done.
        busy_d = (state_d != S_IDLE) || done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= make_result('0);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            m_q  <= m_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = res_q.product;
    assign z_flag  = res_q.z_flag;
    assign n_flag  = res_q.n_flag;

endmodule
